// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the 16-way bus arbiter.
// Arbiter FSM states, select width and one-hot decode.
package bus_arb_pkg;

   localparam int NREQ   = 16;
   localparam int SEL_W  = 4;
   localparam int HCNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_e;

   function automatic logic [NREQ-1:0] onehot4to16(
      input logic [SEL_W-1:0] idx
   );
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr16_pick.sv
// Rotating priority encoder: first set req bit at or after ptr.
// Pure combinational; reusable by any 16-way shared-resource arbiter.
module rr_pick16
   import bus_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] win,
   output logic             any
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [SEL_W-1:0]  off;

   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[NREQ-1:0];
      off = '0;
      // Walk downward so the lowest rotated index wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = SEL_W'(i);
         end
      end
      any = |req;
      win = ptr + off;
   end

endmodule

// File: rtl/bus_arbiter_rr16.sv
// Round-robin owner of the 32-bit internal bus, 16 requesters.
// BUS_ARB_PRIO0_EN: source 0 gets fixed priority and no hold limit.
module bus_arbiter_rr16
   import bus_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [NREQ-1:0]  grant,
   output logic [SEL_W-1:0] sel,
   output logic             bus_valid,
   output logic             timeout
);

   arb_state_e        state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;

   logic [SEL_W-1:0]  pick_win;
   logic              pick_any;
   logic [SEL_W-1:0]  win;
   logic              exempt;
   logic              owner_req;
   logic              hold_max;
   logic              end_ten;

   rr_pick16 u_pick (
      .req (req),
      .ptr (ptr_q),
      .win (pick_win),
      .any (pick_any)
   );

`ifdef BUS_ARB_PRIO0_EN
   assign win    = req[0] ? '0 : pick_win;
   assign exempt = (sel_q == '0);
`else
   assign win    = pick_win;
   assign exempt = 1'b0;
`endif

   // Only the owner's request bit is looked at during a tenure.
   assign owner_req = req[sel_q];
   assign hold_max  = (hcnt_q == HCNT_W'(MAX_HOLD)) && !exempt;
   assign end_ten   = done || !owner_req || hold_max;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            valid_d = 1'b0;
            if (pick_any) begin
               grant_d = onehot4to16(win);
               sel_d   = win;
               valid_d = 1'b1;
               hcnt_d  = HCNT_W'(1);
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (end_ten) begin
               grant_d   = '0;
               valid_d   = 1'b0;
               ptr_d     = sel_q + SEL_W'(1);
               timeout_d = hold_max && !done && owner_req;
               state_d   = TURN;
            end else if (hcnt_q != '1) begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
         end
         TURN: begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= '0;
         hcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign bus_valid = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr16.sv
// Directed plus random bench for bus_arbiter_rr16.
// Reference model tracks owner, tenure length, gap and pointer as integers.
module tb_bus_arbiter_rr16;

   localparam int MH = 8;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic [15:0] req   = '0;
   logic        done  = 1'b0;
   logic [15:0] grant;
   logic [3:0]  sel;
   logic        bus_valid;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   int m_owner = -1;
   int m_len   = 0;
   int m_ptr   = 0;
   int m_sel   = 0;
   int m_gap   = 0;
   bit m_to    = 0;

   always #5 clock = ~clock;

   bus_arbiter_rr16 #(.MAX_HOLD(MH)) dut (
      .clock     (clock),
      .clear     (clear),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .sel       (sel),
      .bus_valid (bus_valid),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge from the current inputs.
   task automatic model_step();
      bit exempt;
      bit capped;
      int w;
      if (clear) begin
         m_owner = -1; m_len = 0; m_ptr = 0;
         m_sel = 0; m_gap = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (m_owner >= 0) begin
            exempt = 0;
`ifdef BUS_ARB_PRIO0_EN
            exempt = (m_owner == 0);
`endif
            capped = (m_len == MH) && !exempt;
            if (done || !req[m_owner] || capped) begin
               m_to    = capped && !done && req[m_owner];
               m_ptr   = (m_owner + 1) % 16;
               m_owner = -1;
               m_gap   = 1;
            end else begin
               m_len++;
            end
         end else if (m_gap != 0) begin
            m_gap = 0;
         end else begin
            w = -1;
            for (int k = 0; k < 16; k++)
               if (w < 0 && req[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
`ifdef BUS_ARB_PRIO0_EN
            if (req[0]) w = 0;
`endif
            if (w >= 0) begin
               m_owner = w; m_sel = w; m_len = 1;
            end
         end
      end
   endtask

   task automatic cycle();
      logic [15:0] eg;
      model_step();
      @(posedge clock);
      #1;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk("model_grant", {16'd0, grant}, {16'd0, eg});
      chk("model_sel", {28'd0, sel}, 32'(m_sel));
      chk("model_valid", {31'd0, bus_valid}, {31'd0, m_owner >= 0});
      chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int to_seen;

      // reset / idle
      clear = 1; req = 16'hFFFF;
      run(2);
      chk("rst_grant", {16'd0, grant}, 32'h0);
      chk("rst_sel", {28'd0, sel}, 32'h0);
      chk("rst_valid", {31'd0, bus_valid}, 32'h0);
      clear = 0; req = 16'h0010;
      cycle();
      chk("first_grant", {16'd0, grant}, 32'h0010);
      chk("first_sel", {28'd0, sel}, 32'd4);
      done = 1; cycle(); done = 0; req = '0;
      run(2);

      // round robin 0,15,0,15 with two dead cycles between
      clear = 1; cycle(); clear = 0; req = 16'h8001;
      for (int t = 0; t < 4; t++) begin
         cycle();
         chk("rr_sel", {28'd0, sel}, (t % 2 == 1) ? 32'd15 : 32'd0);
         done = 1; cycle(); done = 0;
         chk("rr_gap1", {31'd0, bus_valid}, 32'h0);
         cycle();
         chk("rr_gap2", {31'd0, bus_valid}, 32'h0);
      end

      // timeout after MAX_HOLD cycles
      clear = 1; req = '0; cycle(); clear = 0; req = 16'h0004;
      cycle();
      for (int i = 1; i < MH; i++) begin
         cycle();
         chk("to_hold", {16'd0, grant}, 32'h0004);
      end
      cycle();
      chk("to_pulse", {31'd0, timeout}, 32'h1);
      chk("to_drop", {16'd0, grant}, 32'h0);
      cycle();
      chk("to_once", {31'd0, timeout}, 32'h0);
      cycle();
      chk("to_regrant", {16'd0, grant}, 32'h0004);
      req = '0; done = 1; cycle(); done = 0; run(2);

      // withdrawal by owner 7 in its third cycle
      clear = 1; cycle(); clear = 0; req = 16'h0280;
      cycle();
      chk("wd_grant", {16'd0, grant}, 32'h0080);
      run(2);
      req = 16'h0200;
      cycle();
      chk("wd_drop", {16'd0, grant}, 32'h0);
      chk("wd_noto", {31'd0, timeout}, 32'h0);
      run(2);
      chk("wd_next", {16'd0, grant}, 32'h0200);

      // clear in the middle of a tenure restores ptr=0
      clear = 1; cycle(); clear = 0; req = 16'h0008;
      cycle(); done = 1; cycle(); done = 0; req = 16'h0020;
      run(2);
      chk("cm_own5", {16'd0, grant}, 32'h0020);
      clear = 1; cycle();
      chk("cm_grant", {16'd0, grant}, 32'h0);
      chk("cm_sel", {28'd0, sel}, 32'h0);
      chk("cm_valid", {31'd0, bus_valid}, 32'h0);
      clear = 0; req = 16'h0021;
      cycle();
      chk("cm_src0", {16'd0, grant}, 32'h0001);

      // ptr=3 then req 0009
      clear = 1; cycle(); clear = 0; req = 16'h0004;
      cycle(); done = 1; cycle(); done = 0; req = 16'h0009;
      run(2);
`ifdef BUS_ARB_PRIO0_EN
      chk("pr_pick", {16'd0, grant}, 32'h0001);
`else
      chk("pr_pick", {16'd0, grant}, 32'h0008);
`endif
      to_seen = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (timeout) to_seen++;
      end
`ifdef BUS_ARB_PRIO0_EN
      chk("pr_noto", 32'(to_seen), 32'd0);
      chk("pr_hold", {16'd0, grant}, 32'h0001);
`else
      chk("pr_to", 32'(to_seen), 32'd2);
`endif

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req = 16'($urandom & $urandom);
         done  = ($urandom_range(0, 9) == 0);
         clear = ($urandom_range(0, 149) == 0);
         cycle();
      end
      clear = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
